// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers.
// Grants one requester, latches its byte, strobes start and tracks the frame via uart_tx_ready.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                         clk_int,
    input  logic                         uart_reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         uart_tx_start,
    output logic [DATA_W-1:0]            uart_transmit_data,
    input  logic                         uart_tx_ready,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         arb_busy,
    output logic                         tx_done,
    output logic                         timeout_err
);

    localparam int IDW   = $clog2(NUM_REQ);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_DONE
    } state_t;

    state_t               state_q;
    logic [IDW-1:0]       ptr_q;
    logic [IDW-1:0]       grant_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [NUM_REQ-1:0]   ready_q;
    logic                 start_q;
    logic [DATA_W-1:0]    data_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 to_q;

    logic                 found_d;
    logic [IDW-1:0]       sel_d;
    logic [DATA_W-1:0]    req_bytes [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
        assign req_bytes[g] = req_data[g*DATA_W +: DATA_W];
    end

    // First valid requester searching upward from ptr+1, wrapping at NUM_REQ.
    always_comb begin
        logic [IDW-1:0] idx;
        found_d = 1'b0;
        sel_d   = '0;
        idx     = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = IDW'((32'(ptr_q) + 32'd1 + i) % NUM_REQ);
            if (!found_d && req_valid[idx]) begin
                found_d = 1'b1;
                sel_d   = idx;
            end
        end
    end

    always_ff @(posedge clk_int) begin
        if (!uart_reset) begin
            state_q <= IDLE;
            ptr_q   <= IDW'(NUM_REQ - 1);
            grant_q <= '0;
            cnt_q   <= '0;
            ready_q <= '0;
            start_q <= 1'b0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            ready_q <= '0;
            done_q  <= 1'b0;
            to_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (uart_tx_ready && found_d) begin
                        state_q <= START;
                        start_q <= 1'b1;
                        data_q  <= req_bytes[sel_d];
                        ready_q <= NUM_REQ'(1) << sel_d;
                        grant_q <= sel_d;
                        ptr_q   <= sel_d;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (!uart_tx_ready) begin
                        state_q <= WAIT_DONE;
                        start_q <= 1'b0;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        // Byte is dropped; ptr already points at this requester so the next search moves on.
                        state_q <= IDLE;
                        start_q <= 1'b0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        to_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (uart_tx_ready) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready          = ready_q;
    assign uart_tx_start      = start_q;
    assign uart_transmit_data = data_q;
    assign grant_id           = grant_q;
    assign arb_busy           = busy_q;
    assign tx_done            = done_q;
    assign timeout_err        = to_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: vector table for single-frame and idle-hold
// behaviour, hand sequences for round-robin order, wrap, timeout and mid-frame reset.
module tb_uart_tx_arbiter;

    logic        clk_int = 1'b0;
    logic        uart_reset = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ready;
    logic        uart_tx_start;
    logic [7:0]  uart_transmit_data;
    logic        uart_tx_ready = 1'b1;
    logic [1:0]  grant_id;
    logic        arb_busy;
    logic        tx_done;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    uart_tx_arbiter #(
        .NUM_REQ        (4),
        .DATA_W         (8),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk_int            (clk_int),
        .uart_reset         (uart_reset),
        .req_valid          (req_valid),
        .req_data           (req_data),
        .req_ready          (req_ready),
        .uart_tx_start      (uart_tx_start),
        .uart_transmit_data (uart_transmit_data),
        .uart_tx_ready      (uart_tx_ready),
        .grant_id           (grant_id),
        .arb_busy           (arb_busy),
        .tx_done            (tx_done),
        .timeout_err        (timeout_err)
    );

    always #5 clk_int = ~clk_int;

    typedef struct {
        logic        rst_n;
        logic [3:0]  valid;
        logic [31:0] data;
        logic        ready;
        logic [3:0]  e_rr;
        logic        e_start;
        logic [7:0]  e_data;
        logic [1:0]  e_gid;
        logic        e_busy;
        logic        e_done;
        logic        e_to;
    } vec_t;

    vec_t vec [11];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_int);
        #1;
    endtask

    task automatic do_reset();
        uart_reset = 1'b0;
        tick();
        tick();
        uart_reset = 1'b1;
    endtask

    task automatic wait_start(input string nm);
        int n = 0;
        while (!uart_tx_start && n < 40) begin
            tick();
            n++;
        end
        check({nm, "_start"}, 32'(uart_tx_start), 32'd1);
    endtask

    task automatic run_frame(input int g, input logic [7:0] b, input string nm);
        int n = 0;
        wait_start(nm);
        check({nm, "_req_ready"}, 32'(req_ready), 32'(1 << g));
        check({nm, "_data"}, 32'(uart_transmit_data), 32'(b));
        check({nm, "_gid"}, 32'(grant_id), 32'(g));
        uart_tx_ready = 1'b0;
        tick();
        check({nm, "_start_drop"}, 32'(uart_tx_start), 32'd0);
        tick();
        uart_tx_ready = 1'b1;
        while (!tx_done && n < 10) begin
            tick();
            n++;
        end
        check({nm, "_tx_done"}, 32'(tx_done), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no_finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        //          rst   valid  data          rdy   rr    st    dat    gid   busy  done  to
        vec[0]  = '{1'b0, 4'h0, 32'h00000002, 1'b1, 4'h0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0};
        vec[1]  = '{1'b1, 4'h1, 32'h00000002, 1'b1, 4'h1, 1'b1, 8'h02, 2'd0, 1'b1, 1'b0, 1'b0};
        vec[2]  = '{1'b1, 4'h0, 32'h00000002, 1'b1, 4'h0, 1'b1, 8'h02, 2'd0, 1'b1, 1'b0, 1'b0};
        vec[3]  = '{1'b1, 4'h0, 32'h00000002, 1'b0, 4'h0, 1'b0, 8'h02, 2'd0, 1'b1, 1'b0, 1'b0};
        vec[4]  = '{1'b1, 4'h0, 32'h00000002, 1'b0, 4'h0, 1'b0, 8'h02, 2'd0, 1'b1, 1'b0, 1'b0};
        vec[5]  = '{1'b1, 4'h0, 32'h00000002, 1'b1, 4'h0, 1'b0, 8'h02, 2'd0, 1'b0, 1'b1, 1'b0};
        vec[6]  = '{1'b1, 4'h0, 32'h00000002, 1'b1, 4'h0, 1'b0, 8'h02, 2'd0, 1'b0, 1'b0, 1'b0};
        vec[7]  = '{1'b1, 4'h1, 32'h00000055, 1'b0, 4'h0, 1'b0, 8'h02, 2'd0, 1'b0, 1'b0, 1'b0};
        vec[8]  = '{1'b1, 4'h1, 32'h00000055, 1'b0, 4'h0, 1'b0, 8'h02, 2'd0, 1'b0, 1'b0, 1'b0};
        vec[9]  = '{1'b1, 4'h1, 32'h00000055, 1'b1, 4'h1, 1'b1, 8'h55, 2'd0, 1'b1, 1'b0, 1'b0};
        vec[10] = '{1'b0, 4'h1, 32'h00000055, 1'b1, 4'h0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 11; i++) begin
            uart_reset    = vec[i].rst_n;
            req_valid     = vec[i].valid;
            req_data      = vec[i].data;
            uart_tx_ready = vec[i].ready;
            tick();
            check($sformatf("v%0d_req_ready", i), 32'(req_ready), 32'(vec[i].e_rr));
            check($sformatf("v%0d_start", i), 32'(uart_tx_start), 32'(vec[i].e_start));
            check($sformatf("v%0d_data", i), 32'(uart_transmit_data), 32'(vec[i].e_data));
            check($sformatf("v%0d_gid", i), 32'(grant_id), 32'(vec[i].e_gid));
            check($sformatf("v%0d_busy", i), 32'(arb_busy), 32'(vec[i].e_busy));
            check($sformatf("v%0d_done", i), 32'(tx_done), 32'(vec[i].e_done));
            check($sformatf("v%0d_timeout", i), 32'(timeout_err), 32'(vec[i].e_to));
        end

        // Round-robin order with all requesters continuously valid.
        do_reset();
        req_data      = 32'hA3A2A1A0;
        req_valid     = 4'b1111;
        uart_tx_ready = 1'b1;
        run_frame(0, 8'hA0, "rr0");
        run_frame(1, 8'hA1, "rr1");
        run_frame(2, 8'hA2, "rr2");
        run_frame(3, 8'hA3, "rr3");
        run_frame(0, 8'hA0, "rr4");

        // ptr=2 then 0011: search wraps to requester 0, then 1.
        do_reset();
        req_valid = 4'b0100;
        run_frame(2, 8'hA2, "wrap_setup");
        req_valid = 4'b0011;
        run_frame(0, 8'hA0, "wrap0");
        run_frame(1, 8'hA1, "wrap1");

        // Transmitter never goes busy: start stays up for exactly 16 cycles.
        do_reset();
        req_data  = 32'h44332211;
        req_valid = 4'b0011;
        wait_start("to");
        check("to_gid0", 32'(grant_id), 32'd0);
        cnt = 0;
        while (uart_tx_start && cnt < 40) begin
            cnt++;
            tick();
        end
        check("to_start_cycles", 32'(cnt), 32'd16);
        check("to_err_pulse", 32'(timeout_err), 32'd1);
        check("to_busy_idle", 32'(arb_busy), 32'd0);
        tick();
        check("to_err_clear", 32'(timeout_err), 32'd0);
        check("to_next_start", 32'(uart_tx_start), 32'd1);
        check("to_next_gid", 32'(grant_id), 32'd1);
        check("to_next_data", 32'(uart_transmit_data), 32'h22);

        // Reset while waiting for the frame to finish.
        do_reset();
        req_valid = 4'b0010;
        wait_start("rst");
        check("rst_gid1", 32'(grant_id), 32'd1);
        uart_tx_ready = 1'b0;
        tick();
        tick();
        check("rst_wait_busy", 32'(arb_busy), 32'd1);
        uart_reset = 1'b0;
        tick();
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_start", 32'(uart_tx_start), 32'd0);
        check("rst_data", 32'(uart_transmit_data), 32'd0);
        check("rst_gid", 32'(grant_id), 32'd0);
        check("rst_busy", 32'(arb_busy), 32'd0);
        check("rst_done", 32'(tx_done), 32'd0);
        check("rst_timeout", 32'(timeout_err), 32'd0);
        uart_reset    = 1'b1;
        req_valid     = 4'b1111;
        uart_tx_ready = 1'b1;
        wait_start("rst_after");
        check("rst_after_gid", 32'(grant_id), 32'd0);
        check("rst_after_data", 32'(uart_transmit_data), 32'h11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
